// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that shares one carry-lookahead adder
// among NUMREQ requesters. Each transaction takes two cycles. In IDLE the
// block grants a requester and latches its operands. In EXEC it registers the
// (NUMBITS+1)-bit sum and tags the result with the requester index.

// Carry-lookahead adder. Every carry is the flat sum-of-products of the
// generate/propagate terms, so no carry ripples through the earlier bits.
module nBitCarryLookAheadAdder #(
    parameter int NUMBITS = 4
) (
    input  logic [NUMBITS-1:0] a_in,
    input  logic [NUMBITS-1:0] b_in,
    input  logic               c_in,
    output logic [NUMBITS-1:0] s_out,
    output logic               c_out
);

    logic [NUMBITS-1:0] gen_s;
    logic [NUMBITS-1:0] prop_s;
    logic [NUMBITS:0]   carry_s;

    assign gen_s      = a_in & b_in;
    assign prop_s     = a_in ^ b_in;
    assign carry_s[0] = c_in;

    // Carry i+1 is set when some bit j <= i generates a carry and every bit
    // above j up to i propagates it. It is also set when all bits 0..i
    // propagate the carry-in.
    for (genvar i = 0; i < NUMBITS; i++) begin : g_carry
        logic [i+1:0] term_s;
        for (genvar j = 0; j <= i; j++) begin : g_term
            if (j == i) begin : g_own
                assign term_s[j] = gen_s[j];
            end else begin : g_prop
                assign term_s[j] = gen_s[j] & (&prop_s[i:j+1]);
            end
        end
        assign term_s[i+1]  = (&prop_s[i:0]) & c_in;
        assign carry_s[i+1] = |term_s;
    end

    assign s_out = prop_s ^ carry_s[NUMBITS-1:0];
    assign c_out = carry_s[NUMBITS];

endmodule

// Top level: arbitration FSM, operand registers, shared adder and result
// registers.
module adder_arbiter #(
    parameter  int NUMBITS = 4,
    parameter  int NUMREQ  = 4,
    localparam int IDW     = $clog2(NUMREQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUMREQ-1:0]         req_in,
    input  logic [NUMREQ*NUMBITS-1:0] a_in,
    input  logic [NUMREQ*NUMBITS-1:0] b_in,
    input  logic [NUMREQ-1:0]         c_in,
    output logic [NUMREQ-1:0]         gnt_out,
    output logic [NUMBITS-1:0]        s_out,
    output logic                      c_out,
    output logic                      valid_out,
    output logic [IDW-1:0]            id_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [NUMBITS-1:0]   op_a_q, op_a_d;
    logic [NUMBITS-1:0]   op_b_q, op_b_d;
    logic                 op_c_q, op_c_d;
    logic [IDW-1:0]       win_id_q, win_id_d;
    logic [NUMREQ-1:0]    gnt_q, gnt_d;
    logic [NUMBITS-1:0]   sum_q, sum_d;
    logic                 cout_q, cout_d;
    logic                 valid_q, valid_d;
    logic [IDW-1:0]       id_q, id_d;

    logic [NUMBITS-1:0]   a_arr_s [NUMREQ];
    logic [NUMBITS-1:0]   b_arr_s [NUMREQ];
    logic                 found_s;
    logic [IDW-1:0]       win_s;
    int                   cand_s;
    int                   probe_s;
    logic [NUMBITS-1:0]   add_sum_s;
    logic                 add_cout_s;

    // Split the packed operand buses into per-requester lanes.
    for (genvar r = 0; r < NUMREQ; r++) begin : g_lane
        assign a_arr_s[r] = a_in[r*NUMBITS +: NUMBITS];
        assign b_arr_s[r] = b_in[r*NUMBITS +: NUMBITS];
    end

    // The only adder in the block. It is fed from the operand registers, so
    // the timing path is operand registers -> adder -> result registers.
    nBitCarryLookAheadAdder #(
        .NUMBITS (NUMBITS)
    ) u_adder (
        .a_in  (op_a_q),
        .b_in  (op_b_q),
        .c_in  (op_c_q),
        .s_out (add_sum_s),
        .c_out (add_cout_s)
    );

    // Round-robin search: scan from ptr upward and wrap around. The first
    // request found wins.
    always_comb begin
        found_s = 1'b0;
        win_s   = {IDW{1'b0}};
        cand_s  = 0;
        probe_s = 0;
        for (int k = 0; k < NUMREQ; k++) begin
            probe_s = int'(ptr_q) + k;
            cand_s  = (probe_s >= NUMREQ) ? (probe_s - NUMREQ) : probe_s;
            if (!found_s && req_in[cand_s]) begin
                found_s = 1'b1;
                win_s   = IDW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic. IDLE grants and latches operands. EXEC captures the
    // sum and ignores req_in.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_c_d   = op_c_q;
        win_id_d = win_id_q;
        gnt_d    = {NUMREQ{1'b0}};
        sum_d    = sum_q;
        cout_d   = cout_q;
        valid_d  = 1'b0;
        id_d     = id_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    op_a_d   = a_arr_s[win_s];
                    op_b_d   = b_arr_s[win_s];
                    op_c_d   = c_in[win_s];
                    gnt_d    = {{(NUMREQ-1){1'b0}}, 1'b1} << win_s;
                    ptr_d    = (win_s == IDW'(NUMREQ - 1)) ? {IDW{1'b0}}
                                                           : (win_s + IDW'(1'b1));
                    win_id_d = win_s;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                sum_d   = add_sum_s;
                cout_d  = add_cout_s;
                id_d    = win_id_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. An asynchronous reset clears everything,
    // which also drops any transaction that is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= {IDW{1'b0}};
            op_a_q   <= {NUMBITS{1'b0}};
            op_b_q   <= {NUMBITS{1'b0}};
            op_c_q   <= 1'b0;
            win_id_q <= {IDW{1'b0}};
            gnt_q    <= {NUMREQ{1'b0}};
            sum_q    <= {NUMBITS{1'b0}};
            cout_q   <= 1'b0;
            valid_q  <= 1'b0;
            id_q     <= {IDW{1'b0}};
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_c_q   <= op_c_d;
            win_id_q <= win_id_d;
            gnt_q    <= gnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
        end
    end

    assign gnt_out   = gnt_q;
    assign s_out     = sum_q;
    assign c_out     = cout_q;
    assign valid_out = valid_q;
    assign id_out    = id_q;

endmodule
